// File: rtl/wired_bus_resolver.sv
// Resolves N open-drain style drivers onto one bus level (wired-AND or wired-OR),
// glitch-filters the result, and keeps driver-conflict statistics.
module wired_bus_resolver #(
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int FILT  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     drv_en,
  input  logic [N-1:0]     drv_val,
  input  logic             clr,
  output logic             bus_raw,
  output logic             bus_q,
  output logic             changed,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             conflict_sticky
);

  // Idle level is the pulled level: high for wired-AND, low for wired-OR.
  localparam logic             IDLE      = (MODE == 0) ? 1'b1 : 1'b0;
  localparam logic [3:0]       FILT_LAST = 4'(FILT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic       any_one;
  logic       any_zero;
  logic [3:0] filt_cnt;

  // Only enabled channels participate; an idle bus sees neither a one nor a zero.
  assign any_one  = |(drv_en & drv_val);
  assign any_zero = |(drv_en & ~drv_val);

  always_comb begin
    bus_raw = IDLE;
    if (MODE == 0) begin
      bus_raw = ~any_zero;
    end else begin
      bus_raw = any_one;
    end
  end

  assign conflict = any_one & any_zero;

  // Filter: bus_q adopts bus_raw only after FILT consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q    <= IDLE;
      changed  <= 1'b0;
      filt_cnt <= 4'd0;
    end else begin
      changed <= 1'b0;
      if (bus_raw != bus_q) begin
        if (filt_cnt == FILT_LAST) begin
          bus_q    <= bus_raw;
          changed  <= 1'b1;
          filt_cnt <= 4'd0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= 4'd0;
      end
    end
  end

  // clr wins over a conflict on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end else if (clr) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end else if (conflict) begin
      conflict_sticky <= 1'b1;
      if (conflict_cnt != CNT_MAX) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wired_bus_resolver.sv
// Bench for wired_bus_resolver: a wired-AND instance (FILT=3, CNT_W=8) and a
// wired-OR instance (FILT=1, CNT_W=4) share stimulus and a counting reference model.
module tb_wired_bus_resolver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] drv_en = 4'b0000;
  logic [3:0] drv_val = 4'b0000;
  logic       clr = 1'b0;

  logic       raw0, q0, chg0, conf0, st0;
  logic [7:0] cnt0;
  logic       raw1, q1, chg1, conf1, st1;
  logic [3:0] cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wired_bus_resolver #(.N(4), .MODE(0), .FILT(3), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_val(drv_val), .clr(clr),
    .bus_raw(raw0), .bus_q(q0), .changed(chg0), .conflict(conf0),
    .conflict_cnt(cnt0), .conflict_sticky(st0)
  );

  wired_bus_resolver #(.N(4), .MODE(1), .FILT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_val(drv_val), .clr(clr),
    .bus_raw(raw1), .bus_q(q1), .changed(chg1), .conflict(conf1),
    .conflict_cnt(cnt1), .conflict_sticky(st1)
  );

  // Reference model: per-instance parameters and state, index 0 = AND, 1 = OR.
  int   m_mode [2] = '{0, 1};
  int   m_filt [2] = '{3, 1};
  int   m_cmax [2] = '{255, 15};
  logic m_q    [2];
  int   m_run  [2];
  logic m_chg  [2];
  int   m_cnt  [2];
  logic m_st   [2];

  function automatic int count_level(logic [3:0] en, logic [3:0] val, logic lvl);
    int c = 0;
    for (int i = 0; i < 4; i++) if (en[i] && val[i] == lvl) c++;
    return c;
  endfunction

  function automatic logic f_raw(int mode, logic [3:0] en, logic [3:0] val);
    int ones  = count_level(en, val, 1'b1);
    int zeros = count_level(en, val, 1'b0);
    if (ones + zeros == 0) return (mode == 0);
    if (mode == 0) return (zeros == 0);
    return (ones > 0);
  endfunction

  function automatic logic f_conf(logic [3:0] en, logic [3:0] val);
    return (count_level(en, val, 1'b1) > 0) && (count_level(en, val, 1'b0) > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_q[k]   = (m_mode[k] == 0);
        m_run[k] = 0;
        m_chg[k] = 1'b0;
        m_cnt[k] = 0;
        m_st[k]  = 1'b0;
      end else begin
        m_chg[k] = 1'b0;
        if (f_raw(m_mode[k], drv_en, drv_val) != m_q[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] >= m_filt[k]) begin
            m_q[k]   = ~m_q[k];
            m_run[k] = 0;
            m_chg[k] = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
        if (clr) begin
          m_cnt[k] = 0;
          m_st[k]  = 1'b0;
        end else if (f_conf(drv_en, drv_val)) begin
          if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
          m_st[k] = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string where);
    check({where, " raw0"},  32'(raw0),  32'(f_raw(0, drv_en, drv_val)));
    check({where, " conf0"}, 32'(conf0), 32'(f_conf(drv_en, drv_val)));
    check({where, " q0"},    32'(q0),    32'(m_q[0]));
    check({where, " chg0"},  32'(chg0),  32'(m_chg[0]));
    check({where, " cnt0"},  32'(cnt0),  32'(m_cnt[0]));
    check({where, " st0"},   32'(st0),   32'(m_st[0]));
    check({where, " raw1"},  32'(raw1),  32'(f_raw(1, drv_en, drv_val)));
    check({where, " conf1"}, 32'(conf1), 32'(f_conf(drv_en, drv_val)));
    check({where, " q1"},    32'(q1),    32'(m_q[1]));
    check({where, " chg1"},  32'(chg1),  32'(m_chg[1]));
    check({where, " cnt1"},  32'(cnt1),  32'(m_cnt[1]));
    check({where, " st1"},   32'(st1),   32'(m_st[1]));
  endtask

  task automatic step(input string where);
    @(posedge clk);
    #1;
    compare_all(where);
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] val);
    drv_en  = en;
    drv_val = val;
    #1;
  endtask

  initial begin
    // Reset held across two edges.
    repeat (2) @(posedge clk);
    #1;
    compare_all("in_reset");
    check("rst q0 idle", 32'(q0), 32'd1);
    check("rst q1 idle", 32'(q1), 32'd0);
    rst_n = 1'b1;
    step("post_reset");

    check("idle raw0", 32'(raw0), 32'd1);
    check("idle q0",   32'(q0),   32'd1);
    check("idle conf0", 32'(conf0), 32'd0);
    check("idle chg0", 32'(chg0), 32'd0);

    // Disagreeing drivers for three cycles.
    drive(4'b1111, 4'b1110);
    check("dis raw0 now", 32'(raw0), 32'd0);
    check("dis conf0", 32'(conf0), 32'd1);
    step("dis1");
    check("dis q0 e1", 32'(q0), 32'd1);
    step("dis2");
    check("dis q0 e2", 32'(q0), 32'd1);
    step("dis3");
    check("dis q0 e3", 32'(q0), 32'd0);
    check("dis chg0 e3", 32'(chg0), 32'd1);
    check("dis cnt0 e3", 32'(cnt0), 32'd3);
    check("dis st0 e3", 32'(st0), 32'd1);
    step("dis4");
    check("dis chg0 e4", 32'(chg0), 32'd0);

    // Return bus to idle, then a 2-cycle glitch must be filtered.
    drive(4'b0000, 4'b0000);
    repeat (4) step("to_idle");
    check("glitch pre q0", 32'(q0), 32'd1);
    drive(4'b0001, 4'b0000);
    repeat (2) begin
      step("glitch");
      check("glitch q0", 32'(q0), 32'd1);
      check("glitch chg0", 32'(chg0), 32'd0);
    end
    drive(4'b0000, 4'b0000);
    repeat (4) begin
      step("glitch_rel");
      check("glitch rel q0", 32'(q0), 32'd1);
      check("glitch rel chg0", 32'(chg0), 32'd0);
    end

    // Long conflict: saturation, then clr during conflict.
    drive(4'b1111, 4'b0101);
    repeat (300) step("sat");
    check("sat cnt0", 32'(cnt0), 32'd255);
    check("sat cnt1", 32'(cnt1), 32'd15);
    clr = 1'b1;
    step("clr");
    check("clr cnt0", 32'(cnt0), 32'd0);
    check("clr st0", 32'(st0), 32'd0);
    clr = 1'b0;
    step("after_clr");
    check("resume cnt0", 32'(cnt0), 32'd1);
    check("resume st0", 32'(st0), 32'd1);

    // Reset pulse mid-filter discards the partial count.
    drive(4'b0000, 4'b0000);
    repeat (4) step("to_idle2");
    drive(4'b0001, 4'b0000);
    repeat (2) step("pre_rst");
    rst_n = 1'b0;
    #1;
    compare_all("rst_pulse");
    check("rstp q0", 32'(q0), 32'd1);
    check("rstp st0", 32'(st0), 32'd0);
    rst_n = 1'b1;
    step("rel1");
    check("rel1 q0", 32'(q0), 32'd1);
    step("rel2");
    check("rel2 q0", 32'(q0), 32'd1);
    step("rel3");
    check("rel3 q0", 32'(q0), 32'd0);
    check("rel3 chg0", 32'(chg0), 32'd1);

    // Wired-OR instance resolution.
    drive(4'b0000, 4'b0000);
    check("or idle raw1", 32'(raw1), 32'd0);
    drive(4'b0011, 4'b0001);
    check("or raw1", 32'(raw1), 32'd1);
    check("or conf1", 32'(conf1), 32'd1);
    step("or_step");

    // Randomized bursts with occasional clr.
    repeat (150) begin
      int hold;
      drv_en  = 4'($urandom);
      drv_val = 4'($urandom);
      clr     = ($urandom_range(0, 15) == 0);
      hold    = $urandom_range(1, 5);
      #1;
      compare_all("rand_comb");
      repeat (hold) step("rand");
      clr = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
